// File: rtl/fpu_sched.sv
// fpu_sched: round-robin arbiter sharing one fixed-latency FPU between two requesters.
module fpu_sched #(
  parameter int FPU_LATENCY = 8,
  parameter int CNT_W = 8
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op_a,
  input  logic [31:0] req0_op_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op_a,
  input  logic [31:0] req1_op_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_status,
  output logic        resp_flag,
  output logic        busy,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  output logic        fpu_clear,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  input  logic        fpu_flag
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FPU_LATENCY - 1);
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d, rvalid_q, rvalid_d, flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, data_q, data_d;
  logic [3:0] status_q, status_d;
  logic g0, g1;
  // On a tie the requester that did not win last time is granted.
  assign g1 = req1_valid & (~req0_valid | ~last_q);
  assign g0 = req0_valid & ~g1;
  assign req0_ready = (state_q == IDLE) & g0;
  assign req1_ready = (state_q == IDLE) & g1;
  assign busy = state_q != IDLE;
  assign fpu_clear = state_q == CLEAR;
  assign fpu_op_a = op_a_q;
  assign fpu_op_b = op_b_q;
  assign resp_valid = rvalid_q;
  assign resp_id = id_q;
  assign resp_data = data_q;
  assign resp_status = status_q;
  assign resp_flag = flag_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    cnt_d = cnt_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    rvalid_d = rvalid_q;
    data_d = data_q;
    status_d = status_q;
    flag_d = flag_q;
    case (state_q)
      IDLE: if (req0_ready | req1_ready) begin
        state_d = CLEAR;
        id_d = req1_ready;
        last_d = req1_ready;
        op_a_d = req1_ready ? req1_op_a : req0_op_a;
        op_b_d = req1_ready ? req1_op_b : req0_op_b;
      end
      CLEAR: begin
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          data_d = fpu_data;
          status_d = fpu_status;
          flag_d = fpu_flag;
          rvalid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (resp_ready) begin
        rvalid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      cnt_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      rvalid_q <= 1'b0;
      data_q <= '0;
      status_q <= '0;
      flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      rvalid_q <= rvalid_d;
      data_q <= data_d;
      status_q <= status_d;
      flag_q <= flag_d;
    end
  end
endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed checks of arbitration, latency, backpressure and reset abort.
module tb_fpu_sched;
  logic clk = 1'b0, reset = 1'b1;
  logic r0v = 0, r1v = 0, rr = 1;
  logic [31:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
  logic r0r, r1r, rv, rid, rflag, busy, clr;
  logic [31:0] rdata, opa, opb;
  logic [3:0] rstat;
  logic b0v = 0;
  logic [31:0] b0a = 0, b0b = 0;
  logic b0r, b1r, brv, bid, bflag, bbusy, bclr;
  logic [31:0] bdata, bopa, bopb;
  logic [3:0] bstat;
  int cyc = 0;
  logic [31:0] fdata;
  logic [3:0] fstat;
  logic fflag;
  int total = 0, bad = 0, n, h;
  logic [31:0] hv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign fdata = {16'hF0F0, cyc[15:0]};
  assign fstat = cyc[3:0];
  assign fflag = cyc[0];

  fpu_sched #(.FPU_LATENCY(4), .CNT_W(8)) dut (
    .clock100KHz(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0r), .req0_op_a(r0a), .req0_op_b(r0b),
    .req1_valid(r1v), .req1_ready(r1r), .req1_op_a(r1a), .req1_op_b(r1b),
    .resp_valid(rv), .resp_ready(rr), .resp_id(rid), .resp_data(rdata),
    .resp_status(rstat), .resp_flag(rflag), .busy(busy),
    .fpu_op_a(opa), .fpu_op_b(opb), .fpu_clear(clr),
    .fpu_data(fdata), .fpu_status(fstat), .fpu_flag(fflag));

  fpu_sched #(.FPU_LATENCY(1), .CNT_W(4)) dut1 (
    .clock100KHz(clk), .reset(reset),
    .req0_valid(b0v), .req0_ready(b0r), .req0_op_a(b0a), .req0_op_b(b0b),
    .req1_valid(1'b0), .req1_ready(b1r), .req1_op_a(32'h0), .req1_op_b(32'h0),
    .resp_valid(brv), .resp_ready(1'b1), .resp_id(bid), .resp_data(bdata),
    .resp_status(bstat), .resp_flag(bflag), .busy(bbusy),
    .fpu_op_a(bopa), .fpu_op_b(bopb), .fpu_clear(bclr),
    .fpu_data(fdata), .fpu_status(fstat), .fpu_flag(fflag));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rv;
    while (!rv && n < 30) begin
      step;
      n++;
    end
  endtask

  task automatic pulse_reset;
    reset = 1;
    step;
    reset = 0;
  endtask

  initial begin
    step;
    step;
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_rv", rv, 0);
    chk("rst_clr", clr, 0);
    chk("rst_opa", opa, 0);
    chk("rst_data", rdata, 0);
    chk("rst_rdy0", r0r, 0);
    // single operation on requester 0
    r0v = 1; r0a = 32'h3F800000; r0b = 32'h40000000;
    #1;
    h = cyc;
    chk("s_rdy0", r0r, 1);
    chk("s_rdy1", r1r, 0);
    step;
    r0v = 0;
    chk("s_clr", clr, 1);
    chk("s_rdy0_off", r0r, 0);
    chk("s_busy", busy, 1);
    chk("s_opa", opa, 32'h3F800000);
    chk("s_opb", opb, 32'h40000000);
    step;
    chk("s_clr_off", clr, 0);
    n = 2;
    wait_rv;
    chk("s_lat", n, 6);
    hv = h + 5;
    chk("s_id", rid, 0);
    chk("s_data", rdata, {16'hF0F0, hv[15:0]});
    chk("s_stat", rstat, hv[3:0]);
    chk("s_flag", rflag, hv[0]);
    step;
    chk("s_done_busy", busy, 0);
    chk("s_done_rv", rv, 0);
    chk("s_opa_kept", opa, 32'h3F800000);
    // both requesters valid: alternate grants starting from 0
    pulse_reset;
    r0v = 1; r1v = 1; r0a = 32'hA0; r1a = 32'hB1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(r0r | r1r) && n < 30) begin
        step;
        n++;
      end
      chk("rr_grant1", r1r, i % 2);
      chk("rr_grant0", r0r, 1 - i % 2);
      step;
      chk("rr_opa", opa, (i % 2) ? 32'hB1 : 32'hA0);
      n = 0;
      wait_rv;
      chk("rr_id", rid, i % 2);
      step;
    end
    r0v = 0; r1v = 0;
    // backpressure holds the response and blocks new grants
    pulse_reset;
    rr = 0; r0v = 1;
    #1;
    h = cyc;
    chk("bp_rdy0", r0r, 1);
    step;
    r0v = 0; r1v = 1;
    n = 1;
    wait_rv;
    chk("bp_lat", n, 6);
    hv = h + 5;
    for (int i = 0; i < 10; i++) begin
      step;
      chk("bp_rv", rv, 1);
      chk("bp_data", rdata, {16'hF0F0, hv[15:0]});
      chk("bp_rdy1", r1r, 0);
      chk("bp_busy", busy, 1);
    end
    rr = 1;
    step;
    chk("bp_idle", busy, 0);
    chk("bp_rv_off", rv, 0);
    chk("bp_rdy1_now", r1r, 1);
    step;
    r1v = 0;
    n = 1;
    wait_rv;
    chk("bp_id1", rid, 1);
    step;
    // reset while running aborts the operation
    pulse_reset;
    r0v = 1;
    #1;
    step;
    r0v = 0;
    step;
    step;
    step;
    reset = 1;
    step;
    reset = 0;
    chk("ab_busy", busy, 0);
    chk("ab_rv", rv, 0);
    chk("ab_clr", clr, 0);
    chk("ab_opa", opa, 0);
    r0v = 1; r1v = 1;
    #1;
    chk("ab_rdy0", r0r, 1);
    chk("ab_rdy1", r1r, 0);
    step;
    r0v = 0; r1v = 0;
    n = 1;
    wait_rv;
    step;
    // lone requester 1 served back-to-back
    pulse_reset;
    r1v = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("solo_rdy1", r1r, 1);
      step;
      n = 1;
      wait_rv;
      chk("solo_lat", n, 6);
      chk("solo_id", rid, 1);
      step;
    end
    r1v = 0;
    // latency of one cycle
    b0v = 1; b0a = 32'h11; b0b = 32'h22;
    #1;
    h = cyc;
    chk("l1_rdy", b0r, 1);
    step;
    b0v = 0;
    chk("l1_clr", bclr, 1);
    chk("l1_opb", bopb, 32'h22);
    n = 1;
    while (!brv && n < 30) begin
      step;
      n++;
    end
    chk("l1_lat", n, 3);
    hv = h + 2;
    chk("l1_data", bdata, {16'hF0F0, hv[15:0]});
    step;
    chk("l1_idle", bbusy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
